rv32v_element_sequencer: RTL

Parametrised element-issue sequencer for the RV32V execute path. It latches a vector op's configuration (vl, vstart, SEW, LMUL) and computes the effective vector length. It then issues NUM_LANES element slots per beat over a valid/ready handshake. Each slot carries its element index, its register-group offset and its byte offset. It sits between decode/vector-CSR state and the lane datapaths.

---
 rtl/rv32v_element_sequencer_if.sv | 40 ++++
 rtl/rv32v_element_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rv32v_element_sequencer_if.sv
// Configuration/issue bundle between decode, rv32v_element_sequencer and the lane datapaths.
// slave = sequencer side, master = decode/lane side.
interface rv32v_element_sequencer_if #(
   parameter int VLEN      = 128,
   parameter int NUM_LANES = 2
);
   localparam int IW = $clog2(VLEN) + 1;
   localparam int BW = $clog2(VLEN / 8);

   logic                    start;
   logic                    abort;
   logic [IW-1:0]           vl;
   logic [IW-1:0]           vstart;
   logic [2:0]              sew;
   logic [2:0]              lmul;
   logic                    out_ready;
   logic                    busy;
   logic                    illegal;
   logic                    out_valid;
   logic                    out_last;
   logic [NUM_LANES*IW-1:0] elem_idx;
   logic [NUM_LANES*3-1:0]  reg_off;
   logic [NUM_LANES*BW-1:0] byte_off;
   logic [NUM_LANES-1:0]    lane_active;
   logic [NUM_LANES-1:0]    lane_tail;
   logic                    done;
   logic [1:0]              dbg_state;

   modport slave (
      input  start, abort, vl, vstart, sew, lmul, out_ready,
      output busy, illegal, out_valid, out_last, elem_idx, reg_off, byte_off,
             lane_active, lane_tail, done, dbg_state
   );

   modport master (
      output start, abort, vl, vstart, sew, lmul, out_ready,
      input  busy, illegal, out_valid, out_last, elem_idx, reg_off, byte_off,
             lane_active, lane_tail, done, dbg_state
   );
endinterface

// File: rtl/rv32v_element_sequencer.sv
// Latches a vector op config (vl, vstart, SEW, LMUL) and issues NUM_LANES element slots per beat.
// Optional macro RV32V_SEQ_TAIL_EN: keep issuing past evl up to VLMAX and flag those lanes as tail.
module rv32v_element_sequencer #(
   parameter int VLEN      = 128,
   parameter int NUM_LANES = 2
) (
   input logic                      CLK,
   input logic                      nRST,
   rv32v_element_sequencer_if.slave sif
);
   localparam int            IW         = $clog2(VLEN) + 1;
   localparam int            BW         = $clog2(VLEN / 8);
   localparam logic [IW-1:0] BYTES      = IW'(VLEN / 8);
   localparam logic [IW-1:0] LANES      = IW'(NUM_LANES);
   localparam logic [7:0]    EPR_SHIFT0 = 8'($clog2(VLEN) - 3);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           base_q, base_d;
   logic [IW-1:0]           evl_q, evl_d;
   logic [1:0]              sew_q, sew_d;
   logic [IW-1:0]           vlmax_new, evl_new, end_new, end_d;
   logic                    cfg_bad;
   logic                    illegal_d;
   logic                    out_last_d;
   logic [IW-1:0]           idx, mask;
   logic [7:0]              shamt;
   logic [NUM_LANES*IW-1:0] elem_idx_q, elem_idx_d;
   logic [NUM_LANES*3-1:0]  reg_off_q, reg_off_d;
   logic [NUM_LANES*BW-1:0] byte_off_q, byte_off_d;
   logic [NUM_LANES-1:0]    active_q, active_d;
   logic                    busy_q, illegal_q, out_valid_q, out_last_q, done_q;
`ifdef RV32V_SEQ_TAIL_EN
   logic [IW-1:0]           vlmax_q, vlmax_d;
   logic [NUM_LANES-1:0]    tail_q, tail_d;
`endif

   // Handshake: a beat transfers on a rising edge where out_valid && out_ready; while
   // out_ready is low the beat holds unchanged, and out_valid never depends on out_ready.

   // Config decode from the raw request; only ever consumed through registers.
   always_comb begin
      vlmax_new = BYTES >> sif.sew;
      if (sif.lmul[2]) vlmax_new = vlmax_new >> (4'd8 - {1'b0, sif.lmul});
      else             vlmax_new = vlmax_new << sif.lmul[1:0];
      cfg_bad = (sif.sew >= 3'd3) || (sif.lmul == 3'd4) || (vlmax_new == '0);
      evl_new = (sif.vl < vlmax_new) ? sif.vl : vlmax_new;
`ifdef RV32V_SEQ_TAIL_EN
      end_new = vlmax_new;
`else
      end_new = evl_new;
`endif
   end

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      evl_d     = evl_q;
      sew_d     = sew_q;
      illegal_d = 1'b0;
`ifdef RV32V_SEQ_TAIL_EN
      vlmax_d   = vlmax_q;
`endif
      case (state_q)
         IDLE: begin
            if (sif.start) begin
               if (cfg_bad) begin
                  illegal_d = 1'b1;
               end else begin
                  base_d  = sif.vstart;
                  evl_d   = evl_new;
                  sew_d   = sif.sew[1:0];
`ifdef RV32V_SEQ_TAIL_EN
                  vlmax_d = vlmax_new;
`endif
                  state_d = (sif.vstart >= end_new) ? DONE : RUN;
               end
            end
         end
         RUN: begin
            if (sif.abort) begin
               state_d = IDLE;
            end else if (sif.out_ready) begin
               base_d = base_q + LANES;
               if (out_last_q) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Beat fields are decoded from next-state values so every output leaves a flop.
   always_comb begin
`ifdef RV32V_SEQ_TAIL_EN
      end_d  = vlmax_d;
      tail_d = '0;
`else
      end_d  = evl_d;
`endif
      shamt      = EPR_SHIFT0 - {6'd0, sew_d};
      mask       = (IW'(1) << shamt) - IW'(1);
      idx        = '0;
      elem_idx_d = '0;
      reg_off_d  = '0;
      byte_off_d = '0;
      active_d   = '0;
      out_last_d = (state_d == RUN) && ((base_d + LANES) >= end_d);
      if (state_d == RUN) begin
         for (int l = 0; l < NUM_LANES; l++) begin
            idx                       = base_d + IW'(l);
            elem_idx_d[l*IW +: IW]    = idx;
            reg_off_d[l*3 +: 3]       = 3'(idx >> shamt);
            byte_off_d[l*BW +: BW]    = BW'((idx & mask) << sew_d);
            active_d[l]               = (idx < evl_d);
`ifdef RV32V_SEQ_TAIL_EN
            tail_d[l]                 = (idx >= evl_d) && (idx < vlmax_d);
`endif
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         base_q      <= '0;
         evl_q       <= '0;
         sew_q       <= '0;
         busy_q      <= 1'b0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         elem_idx_q  <= '0;
         reg_off_q   <= '0;
         byte_off_q  <= '0;
         active_q    <= '0;
`ifdef RV32V_SEQ_TAIL_EN
         vlmax_q     <= '0;
         tail_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         evl_q       <= evl_d;
         sew_q       <= sew_d;
         busy_q      <= (state_d != IDLE);
         illegal_q   <= illegal_d;
         out_valid_q <= (state_d == RUN);
         out_last_q  <= out_last_d;
         done_q      <= (state_d == DONE);
         elem_idx_q  <= elem_idx_d;
         reg_off_q   <= reg_off_d;
         byte_off_q  <= byte_off_d;
         active_q    <= active_d;
`ifdef RV32V_SEQ_TAIL_EN
         vlmax_q     <= vlmax_d;
         tail_q      <= tail_d;
`endif
      end
   end

   assign sif.busy        = busy_q;
   assign sif.illegal     = illegal_q;
   assign sif.out_valid   = out_valid_q;
   assign sif.out_last    = out_last_q;
   assign sif.done        = done_q;
   assign sif.elem_idx    = elem_idx_q;
   assign sif.reg_off     = reg_off_q;
   assign sif.byte_off    = byte_off_q;
   assign sif.lane_active = active_q;
   assign sif.dbg_state   = state_q;
`ifdef RV32V_SEQ_TAIL_EN
   assign sif.lane_tail   = tail_q;
`else
   assign sif.lane_tail   = '0;
`endif
endmodule
